fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch controller that drives the 10-bit address of the instruction ROM and sequences the program counter (PC). It presents each fetched 16-bit instruction to the decode stage over a valid/ready handshake. It also handles stalls, taken branches with flush, PC wrap-around, and a HALT opcode that stops fetching. It sits between the instruction ROM (combinational read, same-cycle data) and the decoder.

## Interface
Parameters:
- ADDR_W, 10, PC/ROM address width
- INSTR_W, 16, instruction width
- RESET_PC, 10'd0, PC value loaded on reset

Ports:
- iClock  in  1  single clock; all state updates on rising edge
- iReset_n  in  1  asynchronous, active-low reset
- oAddressPC  out  ADDR_W  address to ROM; equals current PC
- iInstruction  in  INSTR_W  ROM data for oAddressPC, valid in the same cycle
- iEnable  in  1  global run enable; low freezes all state
- iBranchValid  in  1  taken branch/jump request, one cycle
- iBranchTarget  in  ADDR_W  branch destination, sampled when iBranchValid=1
- oInstruction  out  INSTR_W  registered instruction to decoder
- oPC  out  ADDR_W  address oInstruction was fetched from
- oValid  out  1  oInstruction/oPC hold a live instruction
- iReady  in  1  decoder accepts; transfer when oValid && iReady
- oHalted  out  1  sequencer in HALTED state

## Operation
- Opcode field is iInstruction[15:10]. HALT = 6'h3F; every other opcode is fetched normally.
- States: FETCH, HALTED.
- Advance condition: adv = iEnable && (!oValid || iReady).
- FETCH, no branch, adv=1:
  - oInstruction <= iInstruction; oPC <= PC; oValid <= 1; PC <= PC+1.
  - If the captured opcode is HALT, next state is HALTED and PC does not increment.
- FETCH, adv=0 and no branch: all registers hold, and oInstruction/oPC stay stable while oValid=1.
- Branch (iBranchValid=1 and iEnable=1, either state):
  - PC <= iBranchTarget; oValid <= 0 (flush, even if the decoder is accepting this cycle); state <= FETCH.
  - Branch has priority over advance and over HALT capture.
- HALTED:
  - No fetch; PC holds; oHalted=1.
  - The HALT instruction stays presented until transferred, then oValid <= 0.
  - Only a branch or reset leaves HALTED.
- iEnable=0: every register holds, including ones with a pending branch; iBranchValid is ignored.
- PC arithmetic is modulo 2^ADDR_W: 1023+1 wraps to 0, with no flag.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - PC=RESET_PC, oAddressPC=RESET_PC, oInstruction=16'h0000, oPC=0, oValid=0, oHalted=0, state FETCH.
- Fetch latency: 1 cycle from oAddressPC to oValid.
- With iReady held high, throughput is 1 instruction/cycle.
- Branch penalty: 1 bubble cycle. The target instruction is valid 1 cycle after the iBranchValid edge.
- oAddressPC is combinational from the PC register only; there is no path from iReady or iBranchValid to oAddressPC.
- Reset asserted mid-operation: state returns to reset values immediately, independent of the clock. No partially presented instruction survives.
- oValid must never drop without a transfer, except on a flush (branch) or reset.
- oHalted rises on the edge that captures HALT, coincident with oValid presenting it.

## Structure
- Shared package (cpu_pkg) holds:
  - ADDR_W and INSTR_W
  - opcode slice positions [15:10]
  - opcode constants OP_HALT=6'h3F and OP_NOP=6'h00
  - the state enum {FETCH, HALTED}
- Sub-module pc_counter holds the PC register with load (branch), increment, hold and wrap. The top level holds the state machine, the output register and the handshake logic.

## Test plan
- Reset release, ROM[0..3] = 16'h0401, 16'h0802, 16'h0C03, 16'h1004, iReady=1:
  - oValid rises 1 cycle after release.
  - oPC sequence is 0,1,2,3 and oInstruction matches ROM on consecutive cycles.
- Backpressure: iReady=0 for 3 cycles while oValid=1 at oPC=5:
  - oInstruction, oPC=5 and oAddressPC=6 stay stable.
  - On iReady=1, the next cycle shows oPC=6.
- Branch at oPC=8 with iBranchTarget=10'd300:
  - Next cycle oValid=0.
  - The following cycle oPC=300 with ROM[300] presented; addresses 9 and later are never presented.
- Wrap: start at PC=1022 with iReady=1:
  - oPC sequence is 1022, 1023, 0, 1.
- HALT: ROM[12] = 16'hFC00:
  - oHalted=1 with oPC=12.
  - After the transfer, oValid=0 and oAddressPC stays 12 for 20 cycles.
  - A branch to 40 clears oHalted and fetches 40.
- iEnable=0 for 4 cycles mid-stream, with iBranchValid pulsed during that window:
  - No state changes and the branch is ignored.
- Reset asserted mid-stream at oPC=7:
  - oValid=0 and PC=RESET_PC asynchronously, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, opcode field layout and
// the fetch sequencer state encoding.
package cpu_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 10;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    localparam logic [OP_W-1:0] OP_HALT = 6'h3F;
    localparam logic [OP_W-1:0] OP_NOP  = 6'h00;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: branch load, increment, or hold. Wraps
// naturally modulo 2^ADDR_W.
module pc_counter #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: drives the ROM address from the PC and
// presents fetched instructions to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               iClock,
    input  logic               iReset_n,
    output logic [ADDR_W-1:0]  oAddressPC,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iEnable,
    input  logic               iBranchValid,
    input  logic [ADDR_W-1:0]  iBranchTarget,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oValid,
    input  logic               iReady,
    output logic               oHalted
);

    import cpu_pkg::*;

    fetch_state_t       state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               branch, adv, is_halt;
    logic               pc_load, pc_inc;

    assign branch  = iEnable && iBranchValid;
    assign adv     = iEnable && (!valid_q || iReady);
    assign is_halt = (iInstruction[OP_MSB:OP_LSB] == OP_HALT);

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk    (iClock),
        .rst_n  (iReset_n),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (iBranchTarget),
        .pc     (pc)
    );

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // A branch flushes the output register even when the decoder is
    // accepting in the same cycle, and wins over HALT capture.
    always_comb begin
        state_next = state;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        if (branch) begin
            pc_load    = 1'b1;
            valid_d    = 1'b0;
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (adv) begin
                        instr_d = iInstruction;
                        pc_d    = pc;
                        valid_d = 1'b1;
                        if (is_halt) begin
                            state_next = HALTED;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (adv) begin
                        valid_d = 1'b0;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            instr_q <= INSTR_W'({OP_NOP, {OP_LSB{1'b0}}});
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign oAddressPC   = pc;
    assign oInstruction = instr_q;
    assign oPC          = pc_q;
    assign oValid       = valid_q;
    assign oHalted      = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural instruction ROM.
module tb_fetch_sequencer;

    logic        iClock = 1'b0;
    logic        iReset_n;
    logic [9:0]  oAddressPC;
    logic [15:0] iInstruction;
    logic        iEnable;
    logic        iBranchValid;
    logic [9:0]  iBranchTarget;
    logic [15:0] oInstruction;
    logic [9:0]  oPC;
    logic        oValid;
    logic        iReady;
    logic        oHalted;

    logic [15:0] rom [1024];
    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .ADDR_W   (10),
        .INSTR_W  (16),
        .RESET_PC (10'd0)
    ) dut (
        .iClock        (iClock),
        .iReset_n      (iReset_n),
        .oAddressPC    (oAddressPC),
        .iInstruction  (iInstruction),
        .iEnable       (iEnable),
        .iBranchValid  (iBranchValid),
        .iBranchTarget (iBranchTarget),
        .oInstruction  (oInstruction),
        .oPC           (oPC),
        .oValid        (oValid),
        .iReady        (iReady),
        .oHalted       (oHalted)
    );

    always #5 iClock = ~iClock;

    assign iInstruction = rom[oAddressPC];

    // Opcodes 1..62 only, so HALT appears solely where planted.
    function automatic logic [15:0] rom_word(int a);
        logic [5:0] op;
        logic [9:0] lo;
        op = 6'((a % 62) + 1);
        lo = 10'(a + 1);
        return {op, lo};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk_out(input string tag, input int pc_exp, input logic [15:0] ins_exp);
        chk({tag, "_valid"}, 32'(oValid), 32'd1);
        chk({tag, "_pc"}, 32'(oPC), 32'(pc_exp));
        chk({tag, "_instr"}, 32'(oInstruction), 32'(ins_exp));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = rom_word(i);
        rom[12] = 16'hFC00;

        iReset_n      = 1'b0;
        iEnable       = 1'b1;
        iBranchValid  = 1'b0;
        iBranchTarget = '0;
        iReady        = 1'b1;
        #12;
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_addr", 32'(oAddressPC), 32'd0);
        chk("rst_pc", 32'(oPC), 32'd0);
        chk("rst_instr", 32'(oInstruction), 32'h0000);
        chk("rst_halted", 32'(oHalted), 32'd0);

        @(negedge iClock);
        iReset_n = 1'b1;
        step(); chk_out("seq0", 0, 16'h0401);
        step(); chk_out("seq1", 1, 16'h0802);
        step(); chk_out("seq2", 2, 16'h0C03);
        step(); chk_out("seq3", 3, 16'h1004);
        step(); chk_out("seq4", 4, 16'h1405);
        step(); chk_out("seq5", 5, 16'h1806);
        chk("seq5_addr", 32'(oAddressPC), 32'd6);

        iReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("bp_hold", 5, 16'h1806);
            chk("bp_addr", 32'(oAddressPC), 32'd6);
        end
        iReady = 1'b1;
        step(); chk_out("bp_release", 6, 16'h1C07);
        step(); chk_out("seq7", 7, 16'h2008);
        step(); chk_out("seq8", 8, 16'h2409);

        iBranchValid  = 1'b1;
        iBranchTarget = 10'd300;
        step();
        chk("br_flush", 32'(oValid), 32'd0);
        chk("br_addr", 32'(oAddressPC), 32'd300);
        iBranchValid = 1'b0;
        step(); chk_out("br_target", 300, rom_word(300));
        chk("br_halted", 32'(oHalted), 32'd0);
        step(); chk_out("br_next", 301, rom_word(301));

        iBranchValid  = 1'b1;
        iBranchTarget = 10'd1022;
        step();
        chk("wrap_bubble", 32'(oValid), 32'd0);
        iBranchValid = 1'b0;
        step(); chk_out("wrap_1022", 1022, rom_word(1022));
        step(); chk_out("wrap_1023", 1023, rom_word(1023));
        chk("wrap_addr", 32'(oAddressPC), 32'd0);
        step(); chk_out("wrap_0", 0, 16'h0401);
        step(); chk_out("wrap_1", 1, 16'h0802);

        iBranchValid  = 1'b1;
        iBranchTarget = 10'd10;
        step();
        iBranchValid = 1'b0;
        step(); chk_out("h_10", 10, rom_word(10));
        step(); chk_out("h_11", 11, rom_word(11));
        step(); chk_out("h_12", 12, 16'hFC00);
        chk("h_halted", 32'(oHalted), 32'd1);
        chk("h_addr", 32'(oAddressPC), 32'd12);
        step();
        chk("h_xfer_valid", 32'(oValid), 32'd0);
        chk("h_xfer_halted", 32'(oHalted), 32'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("h_park_addr", 32'(oAddressPC), 32'd12);
            chk("h_park_valid", 32'(oValid), 32'd0);
        end
        iBranchValid  = 1'b1;
        iBranchTarget = 10'd40;
        step();
        chk("h_exit_halted", 32'(oHalted), 32'd0);
        chk("h_exit_valid", 32'(oValid), 32'd0);
        chk("h_exit_addr", 32'(oAddressPC), 32'd40);
        iBranchValid = 1'b0;
        step(); chk_out("h_40", 40, rom_word(40));

        step(); chk_out("en_41", 41, rom_word(41));
        iEnable       = 1'b0;
        iBranchValid  = 1'b1;
        iBranchTarget = 10'd500;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out("en_hold", 41, rom_word(41));
            chk("en_addr", 32'(oAddressPC), 32'd42);
        end
        iBranchValid = 1'b0;
        iEnable      = 1'b1;
        step(); chk_out("en_resume", 42, rom_word(42));

        iBranchValid  = 1'b1;
        iBranchTarget = 10'd5;
        step();
        iBranchValid = 1'b0;
        step(); chk_out("mr_5", 5, rom_word(5));
        step(); chk_out("mr_6", 6, rom_word(6));
        step(); chk_out("mr_7", 7, rom_word(7));
        #2;
        iReset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(oValid), 32'd0);
        chk("mr_addr", 32'(oAddressPC), 32'd0);
        chk("mr_pc", 32'(oPC), 32'd0);
        chk("mr_instr", 32'(oInstruction), 32'h0000);
        @(negedge iClock);
        iReset_n = 1'b1;
        step(); chk_out("mr_restart", 0, 16'h0401);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
